// File: rtl/s_mem_init_ctrl.sv
// Single-port access controller for the RC4 S-memory: built-in S[i]=i fill engine plus a
// start/finish handshake serving one read or write at a time, with the fill taking priority.
module s_mem_init_ctrl #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_init,
   output logic              finish_init,
   input  logic              start,
   input  logic              readWrite,
   input  logic [ADDR_W-1:0] FSM_Adr,
   input  logic [DATA_W-1:0] DataIn_fromFSM,
   output logic [DATA_W-1:0] DataOut_toFSM,
   output logic              finish,
   output logic [ADDR_W-1:0] sAdr,
   output logic              sWriteEn,
   output logic [DATA_W-1:0] DataOut_to_s,
   input  logic [DATA_W-1:0] DataIn_from_s
);

   typedef enum logic [2:0] {
      StIdle,
      StRead1,
      StRead2,
      StWrite1,
      StDone
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] adr_q, adr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              done_q, done_d;
   logic              init_op_q, init_op_d;
   logic              init_pending;
   logic              cnt_last;

   assign init_pending = start_init & ~done_q;
   assign cnt_last     = (cnt_q == {ADDR_W{1'b1}});

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      adr_d     = adr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      done_d    = done_q;
      init_op_d = init_op_q;

      unique case (state_q)
         StIdle: begin
            // Init fill wins arbitration; external start waits until fill done or dropped.
            if (init_pending) begin
               adr_d     = cnt_q;
               wdata_d   = DATA_W'(cnt_q);
               init_op_d = 1'b1;
               state_d   = StWrite1;
            end else if (start) begin
               adr_d     = FSM_Adr;
               wdata_d   = DataIn_fromFSM;
               init_op_d = 1'b0;
               state_d   = readWrite ? StWrite1 : StRead1;
            end
         end
         StRead1: begin
            state_d = StRead2;
         end
         StRead2: begin
            rdata_d = DataIn_from_s;
            state_d = StDone;
         end
         StWrite1: begin
            state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
            if (init_op_q) begin
               cnt_d = cnt_q + ADDR_W'(1);
               if (cnt_last) begin
                  done_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Dropping start_init re-arms a full fill on the next request.
      if (!start_init) begin
         done_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         adr_q     <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         done_q    <= 1'b0;
         init_op_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         adr_q     <= adr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         done_q    <= done_d;
         init_op_q <= init_op_d;
      end
   end

   assign sWriteEn      = (state_q == StWrite1);
   assign finish        = (state_q == StDone) && !init_op_q;
   assign finish_init   = done_q;
   assign sAdr          = adr_q;
   assign DataOut_to_s  = wdata_q;
   assign DataOut_toFSM = rdata_q;

endmodule

// File: tb/tb_s_mem_init_ctrl.sv
// Directed self-checking bench for s_mem_init_ctrl with a synchronous-read 256x8 RAM model.
module tb_s_mem_init_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start_init = 1'b0;
   logic       finish_init;
   logic       start = 1'b0;
   logic       readWrite = 1'b0;
   logic [7:0] FSM_Adr = 8'h00;
   logic [7:0] DataIn_fromFSM = 8'h00;
   logic [7:0] DataOut_toFSM;
   logic       finish;
   logic [7:0] sAdr;
   logic       sWriteEn;
   logic [7:0] DataOut_to_s;
   logic [7:0] DataIn_from_s;

   logic [7:0] ram [256];
   logic [7:0] ram_q;
   logic       poke_en = 1'b0;
   logic [7:0] poke_addr = 8'h00;
   logic [7:0] poke_data = 8'h00;
   logic       wipe = 1'b0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   s_mem_init_ctrl #(
      .ADDR_W(8),
      .DATA_W(8)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start_init    (start_init),
      .finish_init   (finish_init),
      .start         (start),
      .readWrite     (readWrite),
      .FSM_Adr       (FSM_Adr),
      .DataIn_fromFSM(DataIn_fromFSM),
      .DataOut_toFSM (DataOut_toFSM),
      .finish        (finish),
      .sAdr          (sAdr),
      .sWriteEn      (sWriteEn),
      .DataOut_to_s  (DataOut_to_s),
      .DataIn_from_s (DataIn_from_s)
   );

   // Synchronous-read RAM; poke/wipe let the bench preload contents while the DUT is idle.
   always @(posedge clk) begin
      if (wipe) begin
         for (int k = 0; k < 256; k++) ram[k] <= 8'hFF;
      end else if (poke_en) begin
         ram[poke_addr] <= poke_data;
      end else if (sWriteEn) begin
         ram[sAdr] <= DataOut_to_s;
      end
      ram_q <= ram[sAdr];
   end
   assign DataIn_from_s = ram_q;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      for (int e = 0; e < 2; e++) begin
         start          = 1'($urandom_range(0, 1));
         start_init     = 1'($urandom_range(0, 1));
         readWrite      = 1'($urandom_range(0, 1));
         FSM_Adr        = 8'($urandom);
         DataIn_fromFSM = 8'($urandom);
         tick;
         checks++;
         if ({sAdr, DataOut_to_s, DataOut_toFSM, sWriteEn, finish, finish_init} !== 27'd0) begin
            failures++;
            $display("FAIL reset_outputs: got adr=%h wd=%h rd=%h we=%b fin=%b fi=%b required all 0",
                     sAdr, DataOut_to_s, DataOut_toFSM, sWriteEn, finish, finish_init);
         end
      end
      start      = 1'b0;
      start_init = 1'b0;
      readWrite  = 1'b0;
      reset      = 1'b1;
      tick;
      checks++;
      if ({sWriteEn, finish, finish_init} !== 3'b000) begin
         failures++;
         $display("FAIL reset_idle: got we=%b fin=%b fi=%b required 000",
                  sWriteEn, finish, finish_init);
      end
   endtask

   task automatic test_init_fill(input string tag);
      int         n_wr;
      int         first_done;
      int         bad_pulse;
      int         stray_fin;
      int         mism;
      logic       prev_we;
      logic [7:0] exp_i;
      n_wr       = 0;
      first_done = -1;
      bad_pulse  = 0;
      stray_fin  = 0;
      prev_we    = 1'b0;
      start_init = 1'b1;
      for (int c = 1; c <= 800; c++) begin
         tick;
         if (sWriteEn) begin
            exp_i = 8'(n_wr);
            checks++;
            if (sAdr !== exp_i || DataOut_to_s !== exp_i) begin
               failures++;
               $display("FAIL %s_write: got adr=%h data=%h required %h", tag, sAdr,
                        DataOut_to_s, exp_i);
            end
            n_wr++;
         end
         if (sWriteEn && prev_we) bad_pulse++;
         if (finish) stray_fin++;
         prev_we = sWriteEn;
         if (finish_init) begin
            first_done = c;
            break;
         end
      end
      checks++;
      if (first_done != 768) begin
         failures++;
         $display("FAIL %s_done_cycle: got %0d required 768", tag, first_done);
      end
      checks++;
      if (n_wr != 256) begin
         failures++;
         $display("FAIL %s_write_count: got %0d required 256", tag, n_wr);
      end
      checks++;
      if (bad_pulse != 0) begin
         failures++;
         $display("FAIL %s_we_pulse_width: got %0d long pulses required 0", tag, bad_pulse);
      end
      checks++;
      if (stray_fin != 0) begin
         failures++;
         $display("FAIL %s_no_finish: got %0d finish pulses required 0", tag, stray_fin);
      end
      for (int c = 0; c < 3; c++) begin
         tick;
         checks++;
         if (finish_init !== 1'b1 || sWriteEn !== 1'b0) begin
            failures++;
            $display("FAIL %s_done_hold: got fi=%b we=%b required fi=1 we=0", tag,
                     finish_init, sWriteEn);
         end
      end
      mism = 0;
      for (int k = 0; k < 256; k++) begin
         exp_i = 8'(k);
         if (ram[k] !== exp_i) mism++;
      end
      checks++;
      if (mism != 0) begin
         failures++;
         $display("FAIL %s_ram_contents: got %0d wrong entries required 0", tag, mism);
      end
   endtask

   task automatic test_read;
      poke_en   = 1'b1;
      poke_addr = 8'h12;
      poke_data = 8'hAA;
      tick;
      poke_en        = 1'b0;
      start          = 1'b1;
      readWrite      = 1'b0;
      FSM_Adr        = 8'h12;
      DataIn_fromFSM = 8'h5C;
      tick;
      checks++;
      if (sAdr !== 8'h12 || sWriteEn !== 1'b0 || finish !== 1'b0) begin
         failures++;
         $display("FAIL read_cycle1: got adr=%h we=%b fin=%b required adr=12 we=0 fin=0",
                  sAdr, sWriteEn, finish);
      end
      tick;
      checks++;
      if (sWriteEn !== 1'b0 || finish !== 1'b0) begin
         failures++;
         $display("FAIL read_cycle2: got we=%b fin=%b required we=0 fin=0", sWriteEn, finish);
      end
      tick;
      checks++;
      if (finish !== 1'b1 || DataOut_toFSM !== 8'hAA || sWriteEn !== 1'b0) begin
         failures++;
         $display("FAIL read_cycle3: got fin=%b data=%h we=%b required fin=1 data=aa we=0",
                  finish, DataOut_toFSM, sWriteEn);
      end
      readWrite      = 1'b1;
      FSM_Adr        = 8'h24;
      DataIn_fromFSM = 8'h75;
      tick;
      checks++;
      if (finish !== 1'b0 || sWriteEn !== 1'b0) begin
         failures++;
         $display("FAIL read_idle: got fin=%b we=%b required fin=0 we=0", finish, sWriteEn);
      end
   endtask

   task automatic test_write_on_finish;
      tick;
      start = 1'b0;
      checks++;
      if (sWriteEn !== 1'b1 || sAdr !== 8'h24 || DataOut_to_s !== 8'h75 || finish !== 1'b0) begin
         failures++;
         $display("FAIL write_cycle1: got we=%b adr=%h wd=%h fin=%b required we=1 adr=24 wd=75 fin=0",
                  sWriteEn, sAdr, DataOut_to_s, finish);
      end
      tick;
      checks++;
      if (finish !== 1'b1 || sWriteEn !== 1'b0 || DataOut_toFSM !== 8'hAA) begin
         failures++;
         $display("FAIL write_cycle2: got fin=%b we=%b rd=%h required fin=1 we=0 rd=aa",
                  finish, sWriteEn, DataOut_toFSM);
      end
      tick;
      checks++;
      if (finish !== 1'b0 || ram[8'h24] !== 8'h75) begin
         failures++;
         $display("FAIL write_result: got fin=%b ram=%h required fin=0 ram=75",
                  finish, ram[8'h24]);
      end
   endtask

   task automatic test_contention;
      int         first_fi;
      int         first_fin;
      logic [7:0] fin_data;
      first_fi  = -1;
      first_fin = -1;
      fin_data  = 8'h00;
      reset     = 1'b0;
      start     = 1'b1;
      readWrite = 1'b0;
      FSM_Adr   = 8'h40;
      start_init = 1'b1;
      tick;
      reset = 1'b1;
      for (int c = 1; c <= 900; c++) begin
         tick;
         if (finish_init && first_fi < 0) first_fi = c;
         if (finish) begin
            first_fin = c;
            fin_data  = DataOut_toFSM;
            break;
         end
      end
      start = 1'b0;
      checks++;
      if (first_fi != 768) begin
         failures++;
         $display("FAIL contention_init_done: got %0d required 768", first_fi);
      end
      checks++;
      if (first_fin != 771) begin
         failures++;
         $display("FAIL contention_finish_cycle: got %0d required 771", first_fin);
      end
      checks++;
      if (fin_data !== 8'h40) begin
         failures++;
         $display("FAIL contention_read_data: got %h required 40", fin_data);
      end
      tick;
      checks++;
      if (finish !== 1'b0) begin
         failures++;
         $display("FAIL contention_pulse: got fin=%b required 0", finish);
      end
   endtask

   task automatic test_reset_mid_fill;
      int hit;
      int first_done;
      hit        = -1;
      first_done = -1;
      reset      = 1'b0;
      tick;
      reset = 1'b1;
      for (int c = 1; c <= 400; c++) begin
         tick;
         if (sWriteEn && sAdr == 8'd100) begin
            hit = c;
            break;
         end
      end
      checks++;
      if (hit != 301) begin
         failures++;
         $display("FAIL midfill_reach_100: got cycle %0d required 301", hit);
      end
      reset = 1'b0;
      tick;
      checks++;
      if (sWriteEn !== 1'b0 || finish_init !== 1'b0 || sAdr !== 8'h00 || finish !== 1'b0) begin
         failures++;
         $display("FAIL midfill_abort: got we=%b fi=%b adr=%h fin=%b required all 0",
                  sWriteEn, finish_init, sAdr, finish);
      end
      reset = 1'b1;
      tick;
      checks++;
      if (sWriteEn !== 1'b1 || sAdr !== 8'h00 || DataOut_to_s !== 8'h00) begin
         failures++;
         $display("FAIL midfill_restart: got we=%b adr=%h wd=%h required we=1 adr=00 wd=00",
                  sWriteEn, sAdr, DataOut_to_s);
      end
      for (int c = 2; c <= 800; c++) begin
         tick;
         if (finish_init) begin
            first_done = c;
            break;
         end
      end
      checks++;
      if (first_done != 768) begin
         failures++;
         $display("FAIL midfill_done_cycle: got %0d required 768", first_done);
      end
   endtask

   task automatic test_reinit;
      wipe = 1'b1;
      tick;
      wipe       = 1'b0;
      start_init = 1'b0;
      tick;
      checks++;
      if (finish_init !== 1'b0 || sWriteEn !== 1'b0) begin
         failures++;
         $display("FAIL reinit_clear: got fi=%b we=%b required fi=0 we=0", finish_init, sWriteEn);
      end
      test_init_fill("reinit");
   endtask

   initial begin
      test_reset;
      tick;
      test_init_fill("init");
      test_read;
      test_write_on_finish;
      test_contention;
      test_reset_mid_fill;
      test_reinit;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/s_mem_init_ctrl.md
Name: s_mem_init_ctrl

Overview:
Single-port access controller for the 256x8 S-memory (synchronous-read RAM) of the RC4 decryption datapath. An integrated init engine fills S[i]=i for every address. A start/finish handshake port then serves single read or write requests from upstream FSMs. The block owns the RAM address, write-enable and write-data pins; the init engine has priority over external requests.

Parameters:
ADDR_W, 8, address width; init fills 2**ADDR_W locations.
DATA_W, 8, data width; init value is i truncated to DATA_W.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
start_init  in  1  level request to run the fill sequence
finish_init  out  1  level, high once fill complete
start  in  1  level request for one external memory operation
readWrite  in  1  0 = read, 1 = write; sampled with start
FSM_Adr  in  ADDR_W  request address
DataIn_fromFSM  in  DATA_W  write data from requester
DataOut_toFSM  out  DATA_W  read data to requester, held until next read
finish  out  1  one-cycle pulse, external operation complete
sAdr  out  ADDR_W  RAM address, registered
sWriteEn  out  1  RAM write enable
DataOut_to_s  out  DATA_W  RAM write data, registered
DataIn_from_s  in  DATA_W  RAM read data, valid one cycle after address is presented

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset (reset=0 at an edge): state IDLE, init counter 0, init-done flag 0. Outputs: sAdr=0, DataOut_to_s=0, DataOut_toFSM=0, sWriteEn=0, finish=0, finish_init=0.
- Reset mid-operation aborts it: no finish pulse, sWriteEn low from the next cycle, a partial fill must restart.
- Operation FSM states: IDLE, READ1, READ2, WRITE1, DONE. Outputs decode from the registered state (glitch-free).
  - IDLE: sWriteEn=0, finish=0.
  - Request selection in IDLE: if an init fill is pending, issue the next init write. Otherwise, if start=1, latch FSM_Adr into sAdr and DataIn_fromFSM into DataOut_to_s, then go to READ1 if readWrite=0, else WRITE1.
  - READ1: sWriteEn=0; RAM registers sAdr at end of cycle. Next state READ2.
  - READ2: at end of cycle DataOut_toFSM <= DataIn_from_s. Next state DONE.
  - WRITE1: sWriteEn=1 for exactly this cycle, with sAdr and DataOut_to_s stable. Next state DONE.
  - DONE: finish=1 for external operations only; finish stays 0 for init writes. Next state IDLE.
- Latency from the edge that accepts start:
  - Read: finish high in the 3rd cycle, and DataOut_toFSM is already valid in that cycle.
  - Write: finish high in the 2nd cycle.
- start is level-sensitive. If still high when IDLE is re-entered, a new operation begins using the inputs sampled at that edge. Back-to-back ops therefore occur every 4 cycles (read) or 3 cycles (write), including the IDLE cycle.
- Init engine:
  - Pending when start_init=1 and the done flag is 0.
  - Each init write: sAdr=i, DataOut_to_s=i, through the WRITE1/DONE path.
  - Counter i increments on leaving DONE; i wraps from 255 to 0.
  - After the write of i=255 completes, set the done flag. finish_init goes high the cycle after that DONE and stays high while start_init=1.
  - start_init low clears the done flag and finish_init. A later start_init=1 re-runs the full fill from i=0.
  - start_init dropping mid-fill: the write in progress completes; the fill then pauses with the counter held. It resumes from the held counter when start_init returns.
  - Full fill takes 256 x 3 cycles (IDLE, WRITE1, DONE).
- Arbitration: an external start arriving while the fill is pending is not accepted and gets no finish. It is serviced once the fill completes or start_init goes low. Neither source can interrupt an operation already in progress.
- DataOut_toFSM changes only in READ2.

Test Plan:
- Reset: hold reset=0 two edges with random inputs -> all outputs 0, no sWriteEn pulse.
- Init fill: start_init=1 with a RAM model -> 256 single-cycle sWriteEn pulses with sAdr=DataOut_to_s=i for i=0..255 in order. finish_init rises after the last write, stays high, and RAM holds S[i]=i.
- Read: after init, start=1, readWrite=0, FSM_Adr=0x12, RAM returns 0xAA -> sAdr=0x12, sWriteEn stays 0. finish pulses one cycle in the 3rd cycle after acceptance with DataOut_toFSM=0xAA.
- Write on finish: on the finish rising edge switch to readWrite=1, FSM_Adr=0x24, DataIn_fromFSM=0x75 -> one-cycle sWriteEn with sAdr=0x24, DataOut_to_s=0x75. finish pulses 2 cycles after acceptance; DataOut_toFSM stays 0xAA.
- Contention: start=1 and start_init=1 from reset -> no finish until finish_init=1, then the external read is serviced.
- Reset mid-fill at i=100 then re-release -> fill restarts at i=0; re-init via start_init 1->0->1 repeats the full fill.
